ps2_key_controller: RTL and testbench



---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_key_controller_frame_rx.sv | 104 ++++++++++
 rtl/ps2_key_controller.sv | 91 +++++++++
 tb/tb_ps2_key_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path:
// frame-state encoding, set-2 prefix codes and the scan-code-to-note map.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    typedef logic [2:0] note_idx_t;

    typedef struct packed {
        logic      valid;
        note_idx_t idx;
    } note_map_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Maps the home-row keys (A S D F G H J) to C4..B4; anything else is unmapped.
    function automatic note_map_t note_map(input logic [7:0] code);
        note_map_t m;
        m.valid = 1'b1;
        m.idx   = 3'd0;
        case (code)
            8'h1C:   m.idx = 3'd0;
            8'h1B:   m.idx = 3'd1;
            8'h23:   m.idx = 3'd2;
            8'h2B:   m.idx = 3'd3;
            8'h34:   m.idx = 3'd4;
            8'h33:   m.idx = 3'd5;
            8'h3B:   m.idx = 3'd6;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_controller_frame_rx.sv
// PS/2 receive framer: synchronizes the raw lines, detects falling edges of
// the PS/2 clock, assembles 11-bit frames and validates start/parity/stop.
// A watchdog abandons a partial frame when the keyboard goes quiet.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic [CW-1:0]          timeout_reg;
    frame_state_t           state_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic                   parity_reg;

    logic fall_edge;
    logic data_bit;

    // The last synchronizer stage is the "current" line value; the edge
    // needs one more flop holding the previous synced clock.
    assign fall_edge = clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
    assign data_bit  = data_sync_reg[SYNC_STAGES-1];

    // Synchronizers, watchdog counter and frame FSM, all advancing on clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
            timeout_reg   <= '0;
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            parity_reg    <= 1'b0;
            byte_valid    <= 1'b0;
            rx_byte       <= 8'h00;
            frame_err     <= 1'b0;
        end else begin
            byte_valid    <= 1'b0;
            frame_err     <= 1'b0;
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_sync_reg[SYNC_STAGES-1];

            if (fall_edge) begin
                timeout_reg <= '0;
            end else if (timeout_reg != TO_LAST) begin
                timeout_reg <= timeout_reg + 1'b1;
            end

            // An edge arriving in the expiry cycle is consumed normally.
            if (fall_edge) begin
                case (state_reg)
                    IDLE: begin
                        if (!data_bit) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {data_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_reg <= data_bit;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        if ((^{shift_reg, parity_reg}) && data_bit) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE && timeout_reg == TO_LAST) begin
                state_reg <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard controller top: turns validated bytes into key events via the
// set-2 E0/F0 prefix sequence and tracks the most recently pressed note key.
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_extended,
    output logic       frame_error,
    output logic       note_active,
    output note_idx_t  note_idx
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_err;
    logic       ext_reg;
    logic       brk_reg;
    note_map_t  map_hit;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_frame_err)
    );

    // Error pulse is already registered inside the framer.
    assign frame_error = rx_frame_err;
    assign map_hit     = note_map(rx_byte);

    // Prefix decoder and last-pressed-priority held-note tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_break    <= 1'b0;
            key_extended <= 1'b0;
            note_active  <= 1'b0;
            note_idx     <= 3'd0;
        end else begin
            key_valid <= 1'b0;
            if (rx_frame_err) begin
                // A damaged or abandoned frame may have been the real key
                // byte, so any pending prefix no longer applies.
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext_reg <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_reg <= 1'b1;
                end else begin
                    key_valid    <= 1'b1;
                    key_code     <= rx_byte;
                    key_break    <= brk_reg;
                    key_extended <= ext_reg;
                    ext_reg      <= 1'b0;
                    brk_reg      <= 1'b0;
                    if (!ext_reg && map_hit.valid) begin
                        if (!brk_reg) begin
                            note_active <= 1'b1;
                            note_idx    <= map_hit.idx;
                        end else if (map_hit.idx == note_idx) begin
                            // Releasing an older key leaves the newer note sounding.
                            note_active <= 1'b0;
                            note_idx    <= 3'd0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: drives PS/2 frames bit by bit,
// queues the key events each frame should produce, and checks them as the
// DUT emits key_valid, alongside note state and frame_error pulse counts.
module tb_ps2_key_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_extended;
    logic       frame_error;
    logic       note_active;
    logic [2:0] note_idx;

    always #5 clk = ~clk;

    ps2_key_controller #(
        .TIMEOUT_CYCLES (5000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_extended (key_extended),
        .frame_error  (frame_error),
        .note_active  (note_active),
        .note_idx     (note_idx)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    int  total    = 0;
    int  bad      = 0;
    int  cyc      = 0;
    int  fe_seen  = 0;
    int  kv_cyc   = 0;
    int  fall_cyc = 0;
    int  fe0      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clk cycle; outputs sampled 1 ns after the active edge.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_error === 1'b1) fe_seen++;
        if (key_valid === 1'b1) begin
            kv_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_key_valid", {31'd0, key_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("key event code=%02h brk=%0d ext=%0d", key_code, key_break, key_extended);
                chk("ev_code", {24'd0, key_code}, {24'd0, e.code});
                chk("ev_break", {31'd0, key_break}, {31'd0, e.brk});
                chk("ev_ext", {31'd0, key_extended}, {31'd0, e.ext});
            end
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (10) tick();
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (10) tick();
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_bit, input int nbits);
        logic [10:0] f;
        logic        p;
        p = par_ok ? ~(^b) : (^b);
        f = {stop_bit, p, b, 1'b0};
        $display("frame byte=%02h par_ok=%0d stop=%0d bits=%0d", b, par_ok, stop_bit, nbits);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (20) tick();
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1, 11);
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic brk, input logic ext);
        ev_t e;
        e.code = code;
        e.brk  = brk;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    task automatic check_note(input string tag, input logic act, input logic [2:0] idx);
        chk({tag, "_active"}, {31'd0, note_active}, {31'd0, act});
        chk({tag, "_idx"}, {29'd0, note_idx}, {29'd0, idx});
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_kv"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_code"}, {24'd0, key_code}, 32'd0);
        chk({tag, "_brk"}, {31'd0, key_break}, 32'd0);
        chk({tag, "_ext"}, {31'd0, key_extended}, 32'd0);
        chk({tag, "_fe"}, {31'd0, frame_error}, 32'd0);
        chk({tag, "_act"}, {31'd0, note_active}, 32'd0);
        chk({tag, "_idx"}, {29'd0, note_idx}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) tick();

        // Simple make: event and note four cycles after the stop-bit fall.
        expect_ev(8'h1C, 1'b0, 1'b0);
        good(8'h1C);
        chk("make_latency", kv_cyc - fall_cyc, 32'd4);
        check_note("make_1c", 1'b1, 3'd0);

        // Last-pressed priority.
        expect_ev(8'h34, 1'b0, 1'b0);
        good(8'h34);
        check_note("make_34", 1'b1, 3'd4);
        expect_ev(8'h1C, 1'b1, 1'b0);
        good(8'hF0);
        good(8'h1C);
        check_note("break_old", 1'b1, 3'd4);
        expect_ev(8'h34, 1'b1, 1'b0);
        good(8'hF0);
        good(8'h34);
        check_note("break_cur", 1'b0, 3'd0);

        // Extended code: event flagged, note untouched.
        expect_ev(8'h1C, 1'b0, 1'b1);
        good(8'hE0);
        good(8'h1C);
        check_note("ext_1c", 1'b0, 3'd0);

        // Bad parity mid-stream, then a normal release.
        expect_ev(8'h23, 1'b0, 1'b0);
        good(8'h23);
        check_note("make_23", 1'b1, 3'd2);
        fe0 = fe_seen;
        send_frame(8'h23, 1'b0, 1'b1, 11);
        chk("parity_err", fe_seen, fe0 + 1);
        check_note("after_parity", 1'b1, 3'd2);
        expect_ev(8'h23, 1'b1, 1'b0);
        good(8'hF0);
        good(8'h23);
        check_note("release_23", 1'b0, 3'd0);

        // Bad stop bit after an E0 prefix: prefix is dropped.
        fe0 = fe_seen;
        good(8'hE0);
        send_frame(8'h1B, 1'b1, 1'b0, 11);
        chk("stop_err", fe_seen, fe0 + 1);
        expect_ev(8'h1B, 1'b0, 1'b0);
        good(8'h1B);
        check_note("make_1b", 1'b1, 3'd1);

        // Watchdog: abandon after 5 bits, then a full frame decodes.
        fe0 = fe_seen;
        send_frame(8'h2B, 1'b1, 1'b1, 5);
        repeat (5100) tick();
        chk("timeout_err", fe_seen, fe0 + 1);
        expect_ev(8'h2B, 1'b0, 1'b0);
        good(8'h2B);
        check_note("after_timeout", 1'b1, 3'd3);

        // Reset mid-frame while a note is held.
        fe0 = fe_seen;
        send_frame(8'h34, 1'b1, 1'b1, 5);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (5) tick();
        expect_ev(8'h34, 1'b0, 1'b0);
        good(8'h34);
        check_note("after_reset", 1'b1, 3'd4);
        chk("no_err_after_reset", fe_seen, fe0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
